// File: rtl/shift_pkg.sv
// Shared types and constants for the 32-bit shift arbiter slice.
// SHIFT_ARB_ROTATE_EN enables op 11 (rotate right) in shift_core_32.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int SH_W   = 5;

    typedef enum logic [1:0] {
        SH_SRL = 2'b00,
        SH_SLL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [SH_W-1:0]   shamt;
        shift_op_e         op;
    } shift_req_t;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core_32.sv
// Combinational right-shift core with reversal (SLL) and sign fill (SRA).
// With SHIFT_ARB_ROTATE_EN op 11 rotates right, otherwise it is flagged as an error.
module shift_core_32
    import shift_pkg::*;
(
    input  shift_req_t        req_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [DATA_W-1:0] stage;
    logic [DATA_W-1:0] hi;
    logic              fill;
    logic              rot;

    always_comb begin
        rot   = 1'b0;
        err_o = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
        rot   = (req_i.op == SH_ROR);
`else
        err_o = (req_i.op == SH_ROR);
`endif
        fill  = (req_i.op == SH_SRA) && req_i.a[DATA_W-1];
        stage = (req_i.op == SH_SLL) ? bit_rev(req_i.a) : req_i.a;
        hi    = '0;
        // Each stage shifts by 2^k; the bits entering from the top are either
        // the fill bit or, for rotate, the bits leaving at the bottom.
        for (int k = 0; k < SH_W; k++) begin
            hi = rot ? stage : {DATA_W{fill}};
            if (req_i.shamt[k]) begin
                stage = (stage >> (1 << k)) | (hi << (DATA_W - (1 << k)));
            end
        end
        data_o = (req_i.op == SH_SLL) ? bit_rev(stage) : stage;
        if (err_o) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/shift_arbiter_32.sv
// Round-robin arbiter sharing one shift core between two requesters.
// Result held in a one-entry output slot; SHIFT_ARB_ROTATE_EN enables op 11.
module shift_arbiter_32
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [SH_W-1:0]   req0_shamt,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [SH_W-1:0]   req1_shamt,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e            state_q;
    logic              ptr_q;
    logic [DATA_W-1:0] data_q;
    logic              id_q;
    logic              err_q;

    logic              can_accept;
    logic              gnt1;
    logic              accept;
    shift_req_t        sel;
    logic [DATA_W-1:0] core_data;
    logic              core_err;

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    // Port 1 wins when alone or when the pointer favours it.
    assign gnt1       = req1_valid && (!req0_valid || ptr_q);
    assign req0_ready = can_accept && req0_valid && !gnt1;
    assign req1_ready = can_accept && gnt1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        sel = gnt1 ? {req1_a, req1_shamt, shift_op_e'(req1_op)}
                   : {req0_a, req0_shamt, shift_op_e'(req0_op)};
    end

    shift_core_32 u_core (
        .req_i  (sel),
        .data_o (core_data),
        .err_o  (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_q <= FULL;
                FULL:  if (rsp_ready && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                data_q <= core_data;
                id_q   <= gnt1;
                err_q  <= core_err;
                ptr_q  <= !gnt1;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule
